// File: rtl/level_regen_if.sv
// Request/level bundle between an edge-event source and the level regenerator.
// Latency: none; plain wires grouped for port hookup.
// Backpressure: none; busy_o and drop_o report rejected requests instead of stalling.
interface level_regen_if;
  logic rise_i;
  logic fall_i;
  logic level_o;
  logic rise_o;
  logic fall_o;
  logic busy_o;
  logic drop_o;
  logic err_o;

  // Requester side: drives rise/fall pulses and observes the rebuilt level and flags.
  modport master (
    output rise_i, fall_i,
    input  level_o, rise_o, fall_o, busy_o, drop_o, err_o
  );

  // Regenerator side.
  modport slave (
    input  rise_i, fall_i,
    output level_o, rise_o, fall_o, busy_o, drop_o, err_o
  );
endinterface

// File: rtl/level_regen.sv
// Rebuilds a registered level from rise/fall pulses, enforcing min high/low times.
// Latency: accepted request shows on level_o/rise_o/fall_o one cycle later.
// Backpressure: requests inside a hold window are dropped (drop_o) or, with
// LEVEL_REGEN_PEND_EN defined, held in a one-deep pending slot.
module level_regen #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 3,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  level_regen_if.slave bus
);

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    HIGH_HOLD = 2'd1,
    HIGH_IDLE = 2'd2,
    LOW_HOLD  = 2'd3
  } state_t;

  // Counter reload values: the hold state itself counts as one cycle of the level.
  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(MIN_LOW - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;
  logic             busy;
  logic             both_req, opp_req, same_req, pend_apply, take;
`ifdef LEVEL_REGEN_PEND_EN
  logic             pend_q, pend_d;
`endif

  // Hold window: in a hold state with cycles still left to count.
  always_comb begin
    busy = ((state_q == HIGH_HOLD) || (state_q == LOW_HOLD)) && (cnt_q != '0);
  end

  // Classify requests against the current level and compute next state.
  always_comb begin
    both_req = bus.rise_i & bus.fall_i;
    opp_req  = !both_req && (level_q ? bus.fall_i : bus.rise_i);
    same_req = !both_req && (level_q ? bus.rise_i : bus.fall_i);
`ifdef LEVEL_REGEN_PEND_EN
    // A stored request fires at the end of the hold unless cancelled or
    // frozen by a simultaneous pair this cycle.
    pend_apply = pend_q && !same_req && !both_req;
    pend_d     = pend_q;
`else
    pend_apply = 1'b0;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    drop_d  = 1'b0;
    err_d   = both_req;
    take    = 1'b0;

    if (busy) begin
      cnt_d = cnt_q - 1'b1;
`ifdef LEVEL_REGEN_PEND_EN
      if (opp_req) begin
        pend_d = 1'b1;
      end else if (same_req) begin
        pend_d = 1'b0;
      end
`else
      drop_d = opp_req;
`endif
    end else begin
      take = opp_req || pend_apply;
      if (take) begin
`ifdef LEVEL_REGEN_PEND_EN
        pend_d = 1'b0;
`endif
        if (level_q) begin
          state_d = LOW_HOLD;
          cnt_d   = LO_LOAD;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          state_d = HIGH_HOLD;
          cnt_d   = HI_LOAD;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end
      end else if (!both_req) begin
`ifdef LEVEL_REGEN_PEND_EN
        pend_d = 1'b0;
`endif
        // Hold expired with nothing to do: settle into the idle state.
        if (state_q == HIGH_HOLD) begin
          state_d = HIGH_IDLE;
        end else if (state_q == LOW_HOLD) begin
          state_d = LOW_IDLE;
        end
      end
    end
  end

  // State and registered outputs; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOW_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LEVEL_REGEN_PEND_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
`ifdef LEVEL_REGEN_PEND_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.level_o = level_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.busy_o  = busy;
  assign bus.drop_o  = drop_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_level_regen.sv
// Directed bench for level_regen: default-parameter instance plus a MIN=1 instance.
// Latency: outputs compared #1 after each rising edge.
// Backpressure: drop/pending behaviour checked for both builds of the pending option.
module tb_level_regen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  level_regen_if m0 ();
  level_regen_if m1 ();

  level_regen #(.MIN_HIGH(4), .MIN_LOW(3), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (m0.slave)
  );

  level_regen #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (m1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {level, rise, fall, busy, drop, err}
  typedef struct {
    logic       rs;
    logic       r;
    logic       f;
    logic       chk;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [31];

  function automatic logic [5:0] pack0();
    return {m0.level_o, m0.rise_o, m0.fall_o, m0.busy_o, m0.drop_o, m0.err_o};
  endfunction

  function automatic logic [5:0] pack1();
    return {m1.level_o, m1.rise_o, m1.fall_o, m1.busy_o, m1.drop_o, m1.err_o};
  endfunction

  task automatic expect_out(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (level rise fall busy drop err)", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, then return inputs to idle.
  task automatic cyc(input logic rs, input logic r, input logic f,
                     input logic r1, input logic f1);
    rst       = rs;
    m0.rise_i = r;
    m0.fall_i = f;
    m1.rise_i = r1;
    m1.fall_i = f1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m0.rise_i = 1'b0;
    m0.fall_i = 1'b0;
    m1.rise_i = 1'b0;
    m1.fall_i = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    m0.rise_i = 1'b0;
    m0.fall_i = 1'b0;
    m1.rise_i = 1'b0;
    m1.fall_i = 1'b0;

    // Table index = cycle number; inputs of cycle N and outputs expected in cycle N.
    for (int i = 0; i < 31; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b000000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b110100};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100100};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100100};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b100000};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001100};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000100};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b000000};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000001};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000000};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b110100};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100100};
    tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100100};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100000};
    tbl[27] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100000};
    tbl[28] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b100000};
    tbl[29] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100000};
    tbl[30] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b100000};

    #1;
    for (int i = 0; i < 31; i++) begin
      rst       = tbl[i].rs;
      m0.rise_i = tbl[i].r;
      m0.fall_i = tbl[i].f;
      if (tbl[i].chk) expect_out($sformatf("table_c%0d", i), pack0(), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Early fall two cycles after the rise, inside the hold window.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    expect_out("early_rise", pack0(), 6'b110100);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
`ifdef LEVEL_REGEN_PEND_EN
    expect_out("early_pend_k3", pack0(), 6'b100100);
`else
    expect_out("early_drop_k3", pack0(), 6'b100110);
`endif
    cyc(0, 0, 0, 0, 0);
    expect_out("early_k4", pack0(), 6'b100000);
    cyc(0, 0, 0, 0, 0);
`ifdef LEVEL_REGEN_PEND_EN
    expect_out("early_pend_k5", pack0(), 6'b001100);
`else
    expect_out("early_drop_k5", pack0(), 6'b100000);
`endif

    // Early fall followed by a same-direction rise: cancels any stored request.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    expect_out("cancel_k4", pack0(), 6'b100000);
    cyc(0, 0, 0, 0, 0);
    expect_out("cancel_k5", pack0(), 6'b100000);

    // Two early falls in a row: merged when pending, two drops otherwise.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
`ifdef LEVEL_REGEN_PEND_EN
    expect_out("merge_k4", pack0(), 6'b100000);
    cyc(0, 0, 0, 0, 0);
    expect_out("merge_k5", pack0(), 6'b001100);
`else
    expect_out("drop2_k4", pack0(), 6'b100010);
    cyc(0, 0, 0, 0, 0);
    expect_out("drop2_k5", pack0(), 6'b100000);
`endif

    // Reset in the middle of a high hold, then an immediate rise.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    expect_out("midhold_busy", pack0(), 6'b100100);
    cyc(1, 0, 0, 0, 0);
    expect_out("midhold_reset", pack0(), 6'b000000);
    cyc(0, 1, 0, 0, 0);
    expect_out("midhold_rerise", pack0(), 6'b110100);

    // MIN_HIGH = MIN_LOW = 1: toggle every cycle, never busy.
    cyc(1, 0, 0, 0, 0);
    expect_out("min1_reset", pack1(), 6'b000000);
    cyc(0, 0, 0, 1, 0);
    expect_out("min1_rise1", pack1(), 6'b110000);
    cyc(0, 0, 0, 0, 1);
    expect_out("min1_fall1", pack1(), 6'b001000);
    cyc(0, 0, 0, 1, 0);
    expect_out("min1_rise2", pack1(), 6'b110000);
    cyc(0, 0, 0, 0, 1);
    expect_out("min1_fall2", pack1(), 6'b001000);
    cyc(0, 0, 0, 0, 0);
    expect_out("min1_idle", pack1(), 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
